// File: rtl/n64_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : n64_mem_arbiter_if
// Purpose  : Request/acknowledge memory port bundle. The requester uses the
//            master modport and the memory side uses the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface n64_mem_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 16
);
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        wmask;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, write, address, wdata, wmask,
        input  ack, rdata
    );

    modport slave (
        input  req, write, address, wdata, wmask,
        output ack, rdata
    );
endinterface
`default_nettype wire

// File: rtl/n64_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : n64_mem_arbiter
// Purpose  : Round-robin merge of the N64 port (a) and the MCU port (b) onto
//            one memory bus. One access in flight at a time, registered
//            downstream request, watchdog that ends hung accesses with an
//            all-ones error ack and a sticky timeout_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module n64_mem_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    n64_mem_arbiter_if.slave  a,
    n64_mem_arbiter_if.slave  b,
    n64_mem_arbiter_if.master mem,
    output logic              timeout_err
);
    // A zero TIMEOUT disables the watchdog; keep the counter at least 1 bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant_b;
    logic [CNT_W-1:0]  wd_count;

    logic              wd_expired;
    logic              busy_done;
    logic              grant_a;
    logic              any_req;
    logic [DATA_W-1:0] ack_data;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_wmask;

    // Watchdog fires only when memory has not answered in the limit cycle;
    // a real ack in that same cycle takes precedence.
    assign wd_expired = (TIMEOUT != 0) && (wd_count == CNT_W'(TIMEOUT)) && !mem.ack;
    assign busy_done  = mem.ack || wd_expired;

    // A wins when alone, or on a tie when B was granted last.
    assign any_req = a.req || b.req;
    assign grant_a = a.req && (!b.req || last_grant_b);

    // Field mux of the winning requester, captured into mem_* at grant.
    assign sel_write   = grant_a ? a.write   : b.write;
    assign sel_address = grant_a ? a.address : b.address;
    assign sel_wdata   = grant_a ? a.wdata   : b.wdata;
    assign sel_wmask   = grant_a ? a.wmask   : b.wmask;

    // Completion is reported combinationally in the cycle it happens,
    // only to the port that owns the current access.
    assign ack_data = mem.ack ? mem.rdata : {DATA_W{1'b1}};
    assign a.ack    = (state == BUSY_A) && busy_done;
    assign b.ack    = (state == BUSY_B) && busy_done;
    assign a.rdata  = a.ack ? ack_data : '0;
    assign b.rdata  = b.ack ? ack_data : '0;

    // Arbitration FSM, downstream request registers and watchdog counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            wd_count     <= '0;
            timeout_err  <= 1'b0;
            mem.req      <= 1'b0;
            mem.write    <= 1'b0;
            mem.address  <= '0;
            mem.wdata    <= '0;
            mem.wmask    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    wd_count <= '0;
                    if (any_req) begin
                        mem.req      <= 1'b1;
                        mem.write    <= sel_write;
                        mem.address  <= sel_address;
                        mem.wdata    <= sel_wdata;
                        mem.wmask    <= sel_wmask;
                        last_grant_b <= !grant_a;
                        state        <= grant_a ? BUSY_A : BUSY_B;
                    end
                end
                BUSY_A, BUSY_B: begin
                    if (busy_done) begin
                        mem.req <= 1'b0;
                        state   <= IDLE;
                        if (wd_expired) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wd_count <= wd_count + CNT_W'(1);
                    end
                end
                default: begin
                    mem.req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_n64_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_n64_mem_arbiter
// Purpose  : Directed self-checking bench for n64_mem_arbiter (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_n64_mem_arbiter;
    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic clk;
    logic reset;
    logic timeout_err;
    int   errors = 0;
    int   checks = 0;

    n64_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    n64_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();
    n64_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

    n64_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a_if),
        .b          (b_if),
        .mem        (m_if),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_if.req = 0; a_if.write = 0; a_if.address = '0; a_if.wdata = '0; a_if.wmask = 2'b00;
        b_if.req = 0; b_if.write = 0; b_if.address = '0; b_if.wdata = '0; b_if.wmask = 2'b00;
        m_if.ack = 0; m_if.rdata = '0;
        tick();
        tick();
        checks++;
        if ({m_if.req, m_if.write, m_if.wmask} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {m_if.req, m_if.write, m_if.wmask});
        end
        checks++;
        if (m_if.address !== 27'h0 || m_if.wdata !== 16'h0) begin
            errors++; $display("FAIL reset_fields: got addr %h wdata %h want 0/0", m_if.address, m_if.wdata);
        end
        checks++;
        if ({a_if.ack, b_if.ack, timeout_err} !== 3'b000) begin
            errors++; $display("FAIL reset_acks: got %b want 000", {a_if.ack, b_if.ack, timeout_err});
        end
        checks++;
        if (a_if.rdata !== 16'h0 || b_if.rdata !== 16'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", a_if.rdata, b_if.rdata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        a_if.req = 1; a_if.write = 0; a_if.address = 27'h0001000;
        tick();
        checks++;
        if (m_if.req !== 1'b1 || m_if.address !== 27'h0001000) begin
            errors++; $display("FAIL single_grant: got req %b addr %h want 1 0001000", m_if.req, m_if.address);
        end
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                tick();
            end else begin
                tick();
                checks++;
                if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0) begin
                    errors++; $display("FAIL single_early_ack: cycle %0d got %b%b want 00", k, a_if.ack, b_if.ack);
                end
            end
        end
        m_if.ack = 1; m_if.rdata = 16'hBEEF;
        #1;
        checks++;
        if (a_if.ack !== 1'b1 || a_if.rdata !== 16'hBEEF || b_if.ack !== 1'b0) begin
            errors++; $display("FAIL single_ack: got a_ack %b rdata %h b_ack %b want 1 BEEF 0", a_if.ack, a_if.rdata, b_if.ack);
        end
        tick();
        m_if.ack = 0; a_if.req = 0;
        #1;
        checks++;
        if (m_if.req !== 1'b0 || a_if.ack !== 1'b0 || a_if.rdata !== 16'h0) begin
            errors++; $display("FAIL single_release: got req %b ack %b rdata %h want 0 0 0000", m_if.req, a_if.ack, a_if.rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_a;
        do_reset();
        a_if.req = 1; a_if.write = 0; a_if.address = 27'h0000100;
        b_if.req = 1; b_if.write = 0; b_if.address = 27'h0000200;
        for (int i = 0; i < 4; i++) begin
            exp_a    = (i % 2 == 0);
            exp_addr = exp_a ? 27'h0000100 : 27'h0000200;
            tick();
            checks++;
            if (m_if.req !== 1'b1 || m_if.address !== exp_addr) begin
                errors++; $display("FAIL rr_grant: round %0d got req %b addr %h want 1 %h", i, m_if.req, m_if.address, exp_addr);
            end
            m_if.ack = 1; m_if.rdata = 16'h0A00;
            #1;
            checks++;
            if (a_if.ack !== exp_a || b_if.ack !== !exp_a) begin
                errors++; $display("FAIL rr_ack: round %0d got a %b b %b want a %b", i, a_if.ack, b_if.ack, exp_a);
            end
            tick();
            m_if.ack = 0;
            #1;
            checks++;
            if (m_if.req !== 1'b0) begin
                errors++; $display("FAIL rr_idle: round %0d got req %b want 0", i, m_if.req);
            end
        end
        a_if.req = 0; b_if.req = 0;
    endtask

    task automatic test_write_stable();
        b_if.req = 1; b_if.write = 1; b_if.address = 27'h0000300;
        b_if.wdata = 16'h1234; b_if.wmask = 2'b10;
        tick();
        a_if.write = 1; a_if.address = 27'h7FFFFFF; a_if.wdata = 16'hDEAD; a_if.wmask = 2'b01;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (m_if.req !== 1'b1 || m_if.write !== 1'b1 || m_if.address !== 27'h0000300 ||
                m_if.wdata !== 16'h1234 || m_if.wmask !== 2'b10 || b_if.ack !== 1'b0) begin
                errors++; $display("FAIL write_stable: cycle %0d got req %b wr %b addr %h wdata %h mask %b want 1 1 0000300 1234 10",
                                   k, m_if.req, m_if.write, m_if.address, m_if.wdata, m_if.wmask);
            end
            tick();
        end
        m_if.ack = 1; m_if.rdata = 16'h0000;
        #1;
        checks++;
        if (b_if.ack !== 1'b1 || a_if.ack !== 1'b0) begin
            errors++; $display("FAIL write_ack: got a %b b %b want a 0 b 1", a_if.ack, b_if.ack);
        end
        tick();
        m_if.ack = 0; b_if.req = 0; b_if.write = 0;
        a_if.write = 0; a_if.address = '0; a_if.wdata = '0; a_if.wmask = 2'b00;
        #1;
        checks++;
        if (m_if.req !== 1'b0) begin
            errors++; $display("FAIL write_release: got req %b want 0", m_if.req);
        end
    endtask

    task automatic test_ack_at_limit();
        a_if.req = 1; a_if.write = 0; a_if.address = 27'h0000040;
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k < TIMEOUT) begin
                checks++;
                if (a_if.ack !== 1'b0) begin
                    errors++; $display("FAIL limit_early_ack: cycle %0d got %b want 0", k, a_if.ack);
                end
            end
        end
        m_if.ack = 1; m_if.rdata = 16'h1357;
        #1;
        checks++;
        if (a_if.ack !== 1'b1 || a_if.rdata !== 16'h1357) begin
            errors++; $display("FAIL limit_ack: got ack %b rdata %h want 1 1357", a_if.ack, a_if.rdata);
        end
        tick();
        m_if.ack = 0; a_if.req = 0;
        #1;
        checks++;
        if (timeout_err !== 1'b0 || m_if.req !== 1'b0) begin
            errors++; $display("FAIL limit_no_err: got err %b req %b want 0 0", timeout_err, m_if.req);
        end
    endtask

    task automatic test_timeout();
        a_if.req = 1; a_if.write = 0; a_if.address = 27'h0000080;
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k < TIMEOUT) begin
                checks++;
                if (a_if.ack !== 1'b0) begin
                    errors++; $display("FAIL to_early_ack: cycle %0d got %b want 0", k, a_if.ack);
                end
            end
        end
        checks++;
        if (a_if.ack !== 1'b1 || a_if.rdata !== 16'hFFFF || b_if.ack !== 1'b0) begin
            errors++; $display("FAIL to_ack: got ack %b rdata %h b_ack %b want 1 FFFF 0", a_if.ack, a_if.rdata, b_if.ack);
        end
        tick();
        a_if.req = 0;
        #1;
        checks++;
        if (m_if.req !== 1'b0 || timeout_err !== 1'b1 || a_if.ack !== 1'b0) begin
            errors++; $display("FAIL to_after: got req %b err %b ack %b want 0 1 0", m_if.req, timeout_err, a_if.ack);
        end
        a_if.req = 1; a_if.address = 27'h0000090;
        tick();
        checks++;
        if (m_if.req !== 1'b1 || m_if.address !== 27'h0000090) begin
            errors++; $display("FAIL to_next_grant: got req %b addr %h want 1 0000090", m_if.req, m_if.address);
        end
        m_if.ack = 1; m_if.rdata = 16'h5A5A;
        #1;
        checks++;
        if (a_if.ack !== 1'b1 || a_if.rdata !== 16'h5A5A || timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_next_ack: got ack %b rdata %h err %b want 1 5A5A 1", a_if.ack, a_if.rdata, timeout_err);
        end
        tick();
        m_if.ack = 0; a_if.req = 0;
    endtask

    task automatic test_reset_mid_access();
        a_if.req = 1; a_if.write = 0; a_if.address = 27'h00000A0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (m_if.req !== 1'b0) begin
            errors++; $display("FAIL rst_async_req: got %b want 0", m_if.req);
        end
        m_if.ack = 1; m_if.rdata = 16'h7777;
        #1;
        checks++;
        if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0) begin
            errors++; $display("FAIL rst_no_ack: got a %b b %b want 0 0", a_if.ack, b_if.ack);
        end
        tick();
        reset = 1'b1; m_if.ack = 0;
        b_if.req = 1; b_if.write = 0; b_if.address = 27'h00000B0;
        #1;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL rst_err_clear: got %b want 0", timeout_err);
        end
        tick();
        checks++;
        if (m_if.req !== 1'b1 || m_if.address !== 27'h00000A0) begin
            errors++; $display("FAIL rst_first_grant: got req %b addr %h want 1 00000A0", m_if.req, m_if.address);
        end
        m_if.ack = 1; m_if.rdata = 16'h2468;
        #1;
        checks++;
        if (a_if.ack !== 1'b1 || b_if.ack !== 1'b0 || a_if.rdata !== 16'h2468) begin
            errors++; $display("FAIL rst_first_ack: got a %b b %b rdata %h want 1 0 2468", a_if.ack, b_if.ack, a_if.rdata);
        end
        tick();
        m_if.ack = 0; a_if.req = 0; b_if.req = 0;
        // Stray ack while idle must not reach either port.
        m_if.ack = 1; m_if.rdata = 16'h9999;
        #1;
        checks++;
        if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0 || b_if.rdata !== 16'h0) begin
            errors++; $display("FAIL stray_ack: got a %b b %b rdata %h want 0 0 0000", a_if.ack, b_if.ack, b_if.rdata);
        end
        tick();
        m_if.ack = 0;
        #1;
        checks++;
        if (m_if.req !== 1'b0) begin
            errors++; $display("FAIL stray_idle: got req %b want 0", m_if.req);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stable();
        test_ack_at_limit();
        test_timeout();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
